floor_matrix_scanner: RTL



---
 rtl/floor_matrix_scanner_if.sv | 25 ++
 rtl/floor_matrix_scanner.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/floor_matrix_scanner_if.sv
// Floor-indicator bus between the elevator controller and the LED-matrix scanner.
// The controller drives floor; the scanner returns the matrix pins and status.
interface floor_matrix_scanner_if;
  logic [3:0] floor;
  logic [7:0] col_sel;
  logic [7:0] row_data;
  logic       busy;
  logic [3:0] shown_floor;

  modport master (
    output floor,
    input  col_sel,
    input  row_data,
    input  busy,
    input  shown_floor
  );

  modport slave (
    input  floor,
    output col_sel,
    output row_data,
    output busy,
    output shown_floor
  );
endinterface

// File: rtl/floor_matrix_scanner.sv
// 8x8 LED-matrix floor indicator: column scan, digit glyph ROM and vertical scroll on floor change.
// Optional post-scroll blink is compiled in with FLOOR_MATRIX_BLINK_EN.
module floor_matrix_scanner #(
  parameter int FLOORS        = 4,
  parameter int SCAN_DIV      = 1000,
  parameter int SCROLL_FRAMES = 4,
  parameter int BLINK_FRAMES  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  floor_matrix_scanner_if.slave  bus
);

  localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int STEP_W = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST    = DIV_W'(SCAN_DIV - 1);
  localparam logic [STEP_W-1:0] STEP_LAST   = STEP_W'(SCROLL_FRAMES - 1);
  localparam logic [3:0]        FLOOR_LIMIT = 4'(FLOORS);

  // Out-of-range parameters instantiate a non-existent module so elaboration stops.
  if (SCAN_DIV < 1 || SCROLL_FRAMES < 1 || BLINK_FRAMES < 1 || FLOORS < 1 || FLOORS > 9)
  begin : g_param_check
    floor_matrix_scanner_bad_parameter bad_parameter ();
  end

`ifdef FLOOR_MATRIX_BLINK_EN
  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
  typedef enum logic [1:0] {IDLE, SCROLL, BLINK} state_t;
`else
  typedef enum logic [1:0] {IDLE, SCROLL} state_t;
`endif

  state_t              state, state_next;
  logic [3:0]          shown_q, shown_next;
  logic [3:0]          old_q, old_next;
  logic                dir_q, dir_next;
  logic [3:0]          offset_q, offset_next;
  logic [STEP_W-1:0]   step_q, step_next;
`ifdef FLOOR_MATRIX_BLINK_EN
  logic [BLINK_W-1:0]  bcnt_q, bcnt_next;
  logic [2:0]          half_q, half_next;
`endif

  logic [DIV_W-1:0]    div_q;
  logic [2:0]          col_idx;
  logic [7:0]          col_sel_q, row_data_q, row_next;
  logic                div_wrap, frame_tick;
  logic [7:0]          old_col, new_col;
  logic [15:0]         up_cat, down_cat;

  function automatic logic [7:0] glyph(input logic [3:0] f, input logic [2:0] c);
    logic [39:0] cols;  // {c6,c5,c4,c3,c2}; columns 0, 1 and 7 are always dark
    cols = '0;
    case (f)
      4'd0:    cols = 40'h00_00_00_FE_04;
      4'd1:    cols = 40'h8C_92_A2_C2_84;
      4'd2:    cols = 40'h6C_92_92_82_44;
      4'd3:    cols = 40'h20_FE_24_28_30;
      4'd4:    cols = 40'h72_8A_8A_8A_4E;
      4'd5:    cols = 40'h60_92_92_94_78;
      4'd6:    cols = 40'h06_0A_12_E2_02;
      4'd7:    cols = 40'h6C_92_92_92_6C;
      4'd8:    cols = 40'h3C_52_92_92_0C;
      default: cols = '0;
    endcase
    glyph = 8'h00;
    if (f >= FLOOR_LIMIT) begin
      glyph = 8'hFF;
    end else begin
      case (c)
        3'd2:    glyph = cols[7:0];
        3'd3:    glyph = cols[15:8];
        3'd4:    glyph = cols[23:16];
        3'd5:    glyph = cols[31:24];
        3'd6:    glyph = cols[39:32];
        default: glyph = 8'h00;
      endcase
    end
  endfunction

  assign div_wrap   = (div_q == DIV_LAST);
  assign frame_tick = div_wrap && (col_idx == 3'd7);

  always_comb begin
    old_col  = glyph(old_q, col_idx);
    new_col  = glyph(shown_q, col_idx);
    up_cat   = {new_col, old_col} >> offset_q;
    down_cat = {old_col, new_col} >> (4'd8 - offset_q);
    row_next = new_col;
    if (state == SCROLL) begin
      row_next = dir_q ? up_cat[7:0] : down_cat[7:0];
    end
`ifdef FLOOR_MATRIX_BLINK_EN
    if (state == BLINK && !half_q[0]) begin
      row_next = '0;
    end
`endif
  end

  // Scan counters free-run from reset; floor changes never disturb them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q      <= '0;
      col_idx    <= '0;
      col_sel_q  <= '0;
      row_data_q <= '0;
    end else begin
      col_sel_q  <= 8'd1 << col_idx;
      row_data_q <= row_next;
      if (div_wrap) begin
        div_q   <= '0;
        col_idx <= col_idx + 3'd1;
      end else begin
        div_q <= div_q + DIV_W'(1);
      end
    end
  end

  always_comb begin
    state_next  = state;
    shown_next  = shown_q;
    old_next    = old_q;
    dir_next    = dir_q;
    offset_next = offset_q;
    step_next   = step_q;
`ifdef FLOOR_MATRIX_BLINK_EN
    bcnt_next   = bcnt_q;
    half_next   = half_q;
`endif
    case (state)
      IDLE: begin
        if (bus.floor != shown_q) begin
          shown_next  = bus.floor;
          old_next    = shown_q;
          dir_next    = (bus.floor > shown_q);
          offset_next = '0;
          step_next   = '0;
          if (bus.floor < FLOOR_LIMIT) state_next = SCROLL;
        end
      end
      SCROLL: begin
        if (offset_q == 4'd8) begin
`ifdef FLOOR_MATRIX_BLINK_EN
          state_next = BLINK;
          bcnt_next  = '0;
          half_next  = '0;
`else
          state_next = IDLE;
`endif
        end else if (frame_tick) begin
          if (step_q == STEP_LAST) begin
            step_next   = '0;
            offset_next = offset_q + 4'd1;
          end else begin
            step_next = step_q + STEP_W'(1);
          end
        end
      end
`ifdef FLOOR_MATRIX_BLINK_EN
      BLINK: begin
        if (frame_tick) begin
          if (bcnt_q == BLINK_LAST) begin
            bcnt_next = '0;
            if (half_q == 3'd5) state_next = IDLE;
            else                half_next  = half_q + 3'd1;
          end else begin
            bcnt_next = bcnt_q + BLINK_W'(1);
          end
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shown_q  <= '0;
      old_q    <= '0;
      dir_q    <= 1'b0;
      offset_q <= '0;
      step_q   <= '0;
`ifdef FLOOR_MATRIX_BLINK_EN
      bcnt_q   <= '0;
      half_q   <= '0;
`endif
    end else begin
      state    <= state_next;
      shown_q  <= shown_next;
      old_q    <= old_next;
      dir_q    <= dir_next;
      offset_q <= offset_next;
      step_q   <= step_next;
`ifdef FLOOR_MATRIX_BLINK_EN
      bcnt_q   <= bcnt_next;
      half_q   <= half_next;
`endif
    end
  end

  assign bus.col_sel     = col_sel_q;
  assign bus.row_data    = row_data_q;
  assign bus.busy        = (state != IDLE);
  assign bus.shown_floor = shown_q;

endmodule
